pulse_sender: RTL and testbench
===============================

PULSE_SENDER -- requirements
Module: pulse_sender

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronizing ack_i (legal 2..4).
REQ-002 SHALL have parameter CNT_W, default 4, width of the pending-pulse counter (legal 1..8).
REQ-003 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port arst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tvalid_i  input  1  one-cycle pulse to transfer; each high cycle is one event.
REQ-006 SHALL have port ack_i  input  1  toggle acknowledge from destination domain; asynchronous to aclk.
REQ-007 SHALL have port req_o  output  1  toggle request to destination; one level change per event.
REQ-008 SHALL have port busy_o  output  1  high while a request is outstanding (state WAIT_ACK).
REQ-009 SHALL have port pending_o  output  CNT_W  count of accepted events not yet issued on req_o.
REQ-010 SHALL have port drop_o  output  1  one-cycle pulse when an event is discarded.

Function
REQ-011 SHALL synchronize ack_i through SYNC_STAGES flops (ack_s); no other logic SHALL sample ack_i directly.
REQ-012 SHALL implement FSM states IDLE and WAIT_ACK, all outputs registered.
REQ-013 In IDLE, tvalid_i=1 or pending_o>0 SHALL toggle req_o at that edge and move to WAIT_ACK.
REQ-014 In IDLE with tvalid_i=1 and pending_o>0, SHALL issue one event and leave pending_o unchanged (+1 -1).
REQ-015 In IDLE with tvalid_i=0 and pending_o>0, SHALL issue one event and decrement pending_o.
REQ-016 In WAIT_ACK, ack_s==req_o SHALL return to IDLE at that edge; no toggle on that edge (min one IDLE cycle between toggles).
REQ-017 In WAIT_ACK, tvalid_i=1 SHALL be accounted per Configuration, including on the cycle ack completes.
REQ-018 busy_o SHALL equal (state==WAIT_ACK); latency tvalid_i sampled in IDLE -> req_o toggled and busy_o=1 after 1 edge.
REQ-019 Round trip SHALL be: req_o toggle, destination echo on ack_i, SYNC_STAGES edges, then return to IDLE on the next edge.
REQ-020 pending_o SHALL saturate at 2^CNT_W-1, never wrap; an event arriving at saturation SHALL be dropped and pulse drop_o.
REQ-021 drop_o SHALL be high exactly one cycle per dropped event, registered.
REQ-022 ack_s toggling while in IDLE (spurious) SHALL be ignored; no state or output change.

Reset
REQ-023 arst=1 SHALL asynchronously force state=IDLE, req_o=0, busy_o=0, pending_o=0, drop_o=0, sync flops=0.
REQ-024 arst asserted mid-transfer SHALL discard the outstanding request and all pending events; no drop_o for them.
REQ-025 After arst deasserts, the first tvalid_i SHALL be accepted on the first rising edge with arst=0.
REQ-026 Destination side SHALL be reset together; ack_i=0 is required on release, otherwise REQ-022 applies.

Configuration
REQ-027 Macro PULSE_SENDER_QUEUE_EN SHALL select event handling while busy.
REQ-028 With PULSE_SENDER_QUEUE_EN defined: tvalid_i in WAIT_ACK SHALL increment pending_o (saturation per REQ-020).
REQ-029 Without it: tvalid_i in WAIT_ACK SHALL be dropped with a drop_o pulse; pending_o SHALL be constant 0 and no counter logic synthesized.

Verification
REQ-030 Reset: arst=1 for 5 cycles while toggling tvalid_i -> req_o=0, busy_o=0, pending_o=0, drop_o=0 throughout.
REQ-031 Single event: one tvalid_i pulse, ack_i echoes req_o after 7 cycles -> req_o 0->1 one edge later, busy_o high until ack_s matches, then IDLE.
REQ-032 Burst (QUEUE_EN, CNT_W=4): 5 back-to-back pulses -> pending_o peaks at 4; exactly 5 req_o toggles; final pending_o=0; drop_o never high.
REQ-033 Saturation (QUEUE_EN, CNT_W=2, ack held off): 5 pulses while busy -> pending_o stops at 3; drop_o pulses twice.
REQ-034 No queue (macro undefined): 3 pulses while busy -> 3 drop_o pulses, pending_o=0, one req_o toggle total.
REQ-035 Mid-transfer reset: arst pulse while busy_o=1 with pending_o=2 -> all outputs 0 immediately; the next pulse produces req_o 0->1.

Source files
------------

// File: rtl/pulse_sender.sv
// pulse_sender: carries single-cycle events to another clock domain as
// toggles on req_o and waits for the toggle to come back on ack_i.
// Optional macro PULSE_SENDER_QUEUE_EN: when defined, events that arrive
// while busy are counted in pending_o and issued later. When it is not
// defined, those events are dropped and pending_o is tied to zero.
module pulse_sender #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             tvalid_i,
    input  logic             ack_i,
    output logic             req_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             drop_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;

    assign ack_s = sync_q[SYNC_STAGES-1];

`ifdef PULSE_SENDER_QUEUE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt_q;
    assign pending_o = cnt_q;
`else
    assign pending_o = '0;
`endif

    // ack_i comes from the other domain; only this chain samples it
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
        end
    end

    // request/acknowledge handshake with event accounting
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            req_o   <= 1'b0;
            busy_o  <= 1'b0;
            drop_o  <= 1'b0;
`ifdef PULSE_SENDER_QUEUE_EN
            cnt_q   <= '0;
`endif
        end else begin
            drop_o <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef PULSE_SENDER_QUEUE_EN
                    if (tvalid_i || (cnt_q != '0)) begin
                        req_o   <= ~req_o;
                        busy_o  <= 1'b1;
                        state_q <= WAIT_ACK;
                        // a fresh event replaces the queued one it issues
                        if (!tvalid_i) begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
`else
                    if (tvalid_i) begin
                        req_o   <= ~req_o;
                        busy_o  <= 1'b1;
                        state_q <= WAIT_ACK;
                    end
`endif
                end
                WAIT_ACK: begin
                    if (tvalid_i) begin
`ifdef PULSE_SENDER_QUEUE_EN
                        if (cnt_q == CNT_MAX) begin
                            drop_o <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`else
                        drop_o <= 1'b1;
`endif
                    end
                    // no toggle on this edge: forces one IDLE cycle
                    if (ack_s == req_o) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_sender.sv
// tb_pulse_sender: random and directed stimulus for pulse_sender,
// checked every cycle against an event-counting reference model.
module tb_pulse_sender;

    localparam int S   = 2;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

`ifdef PULSE_SENDER_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic          aclk     = 1'b0;
    logic          arst     = 1'b1;
    logic          tvalid_i = 1'b0;
    logic          ack_i    = 1'b0;
    logic          req_o;
    logic          busy_o;
    logic [CW-1:0] pending_o;
    logic          drop_o;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    pulse_sender #(
        .SYNC_STAGES(S),
        .CNT_W      (CW)
    ) dut (
        .aclk     (aclk),
        .arst     (arst),
        .tvalid_i (tvalid_i),
        .ack_i    (ack_i),
        .req_o    (req_o),
        .busy_o   (busy_o),
        .pending_o(pending_o),
        .drop_o   (drop_o)
    );

    // reference model: totals of accepted and issued events
    int m_acc  = 0;
    int m_iss  = 0;
    bit m_busy = 1'b0;
    bit m_drop = 1'b0;
    bit hist[$];

    task automatic m_clear();
        m_acc  = 0;
        m_iss  = 0;
        m_busy = 1'b0;
        m_drop = 1'b0;
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(1'b0);
    endtask

    // model advances one clock; ack seen is ack_i from S edges ago
    always @(posedge aclk) begin
        bit seen;
        if (arst) begin
            m_clear();
        end else begin
            seen = hist.pop_front();
            hist.push_back(ack_i);
            m_drop = 1'b0;
            if (!m_busy) begin
                if (tvalid_i) m_acc++;
                if (m_acc > m_iss) begin
                    m_iss++;
                    m_busy = 1'b1;
                end
            end else begin
                if (tvalid_i) begin
                    if (QEN && (m_acc - m_iss) < MAX) m_acc++;
                    else m_drop = 1'b1;
                end
                if (seen == bit'(m_iss % 2)) m_busy = 1'b0;
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // destination echo: copies req_o to ack_i after dly cycles
    int dly  = 3;
    int dcnt = 0;
    bit hold = 1'b0;

    task automatic step(bit tv);
        @(negedge aclk);
        chk("req", 32'(req_o), 32'(m_iss % 2));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("pending", 32'(pending_o), 32'(m_acc - m_iss));
        chk("drop", 32'(drop_o), 32'(m_drop));
        if (!hold && !arst && (ack_i !== req_o)) begin
            if (dcnt >= dly) begin
                ack_i = req_o;
                dcnt  = 0;
                dly   = $urandom_range(0, 10);
            end else begin
                dcnt++;
            end
        end
        tvalid_i = tv;
    endtask

    initial begin
        int n;
        // reset held while tvalid_i toggles
        arst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(bit'(i % 2));
            chk("rst_req", 32'(req_o), 32'd0);
            chk("rst_pend", 32'(pending_o), 32'd0);
        end
        arst = 1'b0;
        // single event, echo after 7 cycles
        dly = 7;
        step(1'b1);
        step(1'b0);
        chk("single_req", 32'(req_o), 32'd1);
        chk("single_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0);
        chk("single_idle", 32'(busy_o), 32'd0);
        // burst of back-to-back pulses
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 80; i++) step(1'b0);
        // ack held off: saturation or drops
        hold = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b1);
        hold = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) == 0);
        // reset while a request is outstanding
        n = 0;
        while (!busy_o && n < 50) begin
            step(1'b1);
            n++;
        end
        chk("mid_busy", 32'(busy_o), 32'd1);
        step(1'b1);
        step(1'b1);
        arst  = 1'b1;
        ack_i = 1'b0;
        dcnt  = 0;
        #1;
        chk("mid_req", 32'(req_o), 32'd0);
        chk("mid_busy0", 32'(busy_o), 32'd0);
        chk("mid_pend", 32'(pending_o), 32'd0);
        chk("mid_drop", 32'(drop_o), 32'd0);
        step(1'b0);
        step(1'b0);
        arst = 1'b0;
        step(1'b1);
        step(1'b0);
        chk("post_req", 32'(req_o), 32'd1);
        for (int i = 0; i < 40; i++) step(1'b0);
        chk("final_busy", 32'(busy_o), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
